// File: rtl/qgemm_tile_reader_pkg.sv
// Shared qgemm definitions: SRAM geometry defaults and the tile reader FSM encoding.
package qgemm_tile_reader_pkg;

    localparam int QGEMM_BW_CELL_INDEX    = 8;
    localparam int QGEMM_CELL_ARRAY_WIDTH = 512;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } reader_state_e;

endpackage

// File: rtl/qgemm_tile_reader_if.sv
// Command, SRAM read and row output bundle of the tile reader, plus its FSM state for observation.
interface qgemm_tile_reader_if
    import qgemm_tile_reader_pkg::*;
#(
    parameter int BW_CELL_INDEX    = QGEMM_BW_CELL_INDEX,
    parameter int CELL_ARRAY_WIDTH = QGEMM_CELL_ARRAY_WIDTH
);

    // valid/ready: a transfer happens on a clock edge where both are high; the sender
    // keeps its payload stable from raising valid until that edge.
    logic                        cmd_valid;
    logic                        cmd_ready;
    logic [BW_CELL_INDEX-1:0]    cmd_base_index;
    logic [BW_CELL_INDEX:0]      cmd_num_rows;
    logic [BW_CELL_INDEX-1:0]    cmd_stride;

    logic                        mem_renable;
    logic [BW_CELL_INDEX-1:0]    mem_index;
    logic [CELL_ARRAY_WIDTH-1:0] mem_rdata;
    logic                        mem_rvalid;

    logic                        out_valid;
    logic                        out_ready;
    logic [CELL_ARRAY_WIDTH-1:0] out_data;
    logic                        out_last;

    logic                        busy;
    logic                        done;
    reader_state_e               state;

    // master: command issuer / SRAM / row consumer side; slave: the tile reader
    modport master (
        output cmd_valid, cmd_base_index, cmd_num_rows, cmd_stride,
        output mem_rdata, mem_rvalid, out_ready,
        input  cmd_ready, mem_renable, mem_index, out_valid, out_data, out_last,
        input  busy, done, state
    );

    modport slave (
        input  cmd_valid, cmd_base_index, cmd_num_rows, cmd_stride,
        input  mem_rdata, mem_rvalid, out_ready,
        output cmd_ready, mem_renable, mem_index, out_valid, out_data, out_last,
        output busy, done, state
    );

endinterface

// File: rtl/qgemm_sync_fifo.sv
// Synchronous power-of-two FIFO with occupancy count; head word is visible combinationally.
module qgemm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/qgemm_tile_reader.sv
// Reads a strided run of SRAM rows and streams them out through a small credit-checked FIFO.
module qgemm_tile_reader
    import qgemm_tile_reader_pkg::*;
#(
    parameter int BW_CELL_INDEX    = QGEMM_BW_CELL_INDEX,
    parameter int CELL_ARRAY_WIDTH = QGEMM_CELL_ARRAY_WIDTH,
    parameter int FIFO_DEPTH       = 4
) (
    input logic          clk,
    input logic          rst,
    qgemm_tile_reader_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int RW = BW_CELL_INDEX + 1;

    reader_state_e            state_q;
    reader_state_e            state_d;
    logic [BW_CELL_INDEX-1:0] idx_q;
    logic [BW_CELL_INDEX-1:0] stride_q;
    logic [RW-1:0]            num_rows_q;
    logic [RW-1:0]            issued_q;
    logic                     inflight_q;
    logic                     inflight_last_q;
    logic                     done_q;

    logic                     accept;
    logic                     renable;
    logic                     issue_last;
    logic                     push;
    logic                     pop;
    logic [CW:0]              occupancy;
    logic [CELL_ARRAY_WIDTH:0] fifo_wdata;
    logic [CELL_ARRAY_WIDTH:0] fifo_rdata;
    logic                     fifo_empty;
    logic [CW-1:0]            fifo_count;

    assign accept     = bus.cmd_valid && bus.cmd_ready;
    assign occupancy  = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    assign issue_last = (issued_q == num_rows_q - RW'(1));
    // Only data we asked for is accepted, so a read launched before a reset is dropped.
    assign push       = bus.mem_rvalid && inflight_q;
    assign pop        = !fifo_empty && bus.out_ready;
    assign fifo_wdata = {inflight_last_q, bus.mem_rdata};

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept && bus.cmd_num_rows != '0) state_d = ST_ISSUE;
            ST_ISSUE: if (renable && issue_last)            state_d = ST_DRAIN;
            ST_DRAIN: if (pop && fifo_rdata[CELL_ARRAY_WIDTH]) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // A read is launched only when the FIFO has room for it plus the one already in flight.
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE) && !rst;
        renable       = (state_q == ST_ISSUE) && (occupancy < (CW+1)'(FIFO_DEPTH));
        bus.busy      = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q           <= '0;
            stride_q        <= '0;
            num_rows_q      <= '0;
            issued_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            inflight_q      <= renable;
            inflight_last_q <= renable && issue_last;
            done_q          <= (accept && bus.cmd_num_rows == '0) ||
                               (state_q == ST_DRAIN && state_d == ST_IDLE);
            if (accept) begin
                idx_q      <= bus.cmd_base_index;
                stride_q   <= bus.cmd_stride;
                num_rows_q <= bus.cmd_num_rows;
                issued_q   <= '0;
            end else if (renable) begin
                idx_q    <= idx_q + stride_q;
                issued_q <= issued_q + RW'(1);
            end
        end
    end

    qgemm_sync_fifo #(
        .WIDTH (CELL_ARRAY_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.mem_renable = renable;
    assign bus.mem_index   = idx_q;
    assign bus.out_valid   = !fifo_empty;
    assign bus.out_data    = fifo_rdata[CELL_ARRAY_WIDTH-1:0];
    assign bus.out_last    = fifo_rdata[CELL_ARRAY_WIDTH] && !fifo_empty;
    assign bus.done        = done_q;
    assign bus.state       = state_q;

endmodule
